// File: rtl/zap_normalizer_if.sv
// Request/result bus of the iterative normalizer.
//   slave  : the normalizer (consumes i_*, drives o_*)
//   master : the requester/consumer side
//   i_flush  synchronous abort
//   i_valid/o_ready/i_source  request handshake and operand
//   o_valid/i_ready           result handshake
//   o_result/o_amount/o_zero  normalized value, shift count, zero flag
interface zap_normalizer_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned AW = $clog2(WIDTH) + 1;

  logic             i_flush;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_source;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;
  logic [AW-1:0]    o_amount;
  logic             o_zero;

  modport slave (
    input  i_flush, i_valid, i_source, i_ready,
    output o_ready, o_valid, o_result, o_amount, o_zero
  );

  modport master (
    output i_flush, i_valid, i_source, i_ready,
    input  o_ready, o_valid, o_result, o_amount, o_zero
  );
endinterface

// File: rtl/zap_normalizer.sv
// Iterative normalizer: left-shifts an operand until its leading 1 reaches
// the MSB, examining up to STEP bits per busy cycle.
//   i_clk      clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   bus        zap_normalizer_if.slave (request, result and flush signals)
module zap_normalizer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  zap_normalizer_if.slave  bus
);

  localparam int unsigned AW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] work_q,  work_d;
  logic [AW-1:0]    count_q, count_d;
  logic             zero_q,  zero_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;

  logic             top_zero;
  logic             lz_found;
  logic [AW-1:0]    lz;

  // Leading zeros inside the top STEP bits of the work register.
  always_comb begin
    top_zero = (work_q[WIDTH-1 -: STEP] == '0);
    lz       = '0;
    lz_found = 1'b0;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (!lz_found && work_q[WIDTH-1-i]) begin
        lz       = AW'(i);
        lz_found = 1'b1;
      end
    end
  end

  // Next-state and datapath update; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    count_d = count_q;
    zero_d  = zero_q;

    if (bus.i_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.i_valid) begin
            work_d  = bus.i_source;
            count_d = '0;
            if (bus.i_source == '0) begin
              count_d = AW'(WIDTH);
              zero_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              zero_d  = 1'b0;
              state_d = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (top_zero) begin
            work_d  = work_q << STEP;
            count_d = count_q + AW'(STEP);
          end else begin
            work_d  = work_q << lz;
            count_d = count_q + lz;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (bus.i_ready) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Handshake flags are flopped from the next state so they track state_q.
    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      count_q <= '0;
      zero_q  <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      count_q <= count_d;
      zero_q  <= zero_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign bus.o_ready  = ready_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_result = work_q;
  assign bus.o_amount = count_q;
  assign bus.o_zero   = zero_q;

endmodule

// File: tb/tb_zap_normalizer.sv
// Directed bench for zap_normalizer (STEP=4 main instance, STEP=1/32 sweep).
module tb_zap_normalizer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  zap_normalizer_if #(.WIDTH(32)) n1 ();
  zap_normalizer_if #(.WIDTH(32)) n4 ();
  zap_normalizer_if #(.WIDTH(32)) n32 ();

  zap_normalizer #(.WIDTH(32), .STEP(1)) u_dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(n1.slave));
  zap_normalizer #(.WIDTH(32), .STEP(4)) u_dut4 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(n4.slave));
  zap_normalizer #(.WIDTH(32), .STEP(32)) u_dut32 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(n32.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_clz(input logic [31:0] v);
    int n;
    logic hit;
    n = 32;
    hit = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!hit && v[i]) begin
        n = 31 - i;
        hit = 1'b1;
      end
    end
    return n;
  endfunction

  // Issue one request on the STEP=4 instance; cycles = edges after accept
  // until o_valid is seen (100 on timeout).
  task automatic do_req(input logic [31:0] src, output int cycles);
    @(negedge clk);
    n4.i_valid  = 1'b1;
    n4.i_source = src;
    @(negedge clk);
    n4.i_valid  = 1'b0;
    n4.i_source = 32'hDEAD_BEEF;
    cycles = 0;
    while (!n4.o_valid && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (n4.o_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", n4.o_ready);
    end
    checks++;
    if (n4.o_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", n4.o_valid);
    end
    checks++;
    if (n4.o_result !== 32'h0) begin
      errors++; $display("FAIL reset_result got %h want 0", n4.o_result);
    end
    checks++;
    if (n4.o_amount !== 6'd0) begin
      errors++; $display("FAIL reset_amount got %0d want 0", n4.o_amount);
    end
    checks++;
    if (n4.o_zero !== 1'b0) begin
      errors++; $display("FAIL reset_zero got %b want 0", n4.o_zero);
    end
  endtask

  task automatic test_single_bit();
    int cyc;
    do_req(32'h0000_0001, cyc);
    checks++;
    if (cyc != 8) begin
      errors++; $display("FAIL lsb_latency got %0d want 8", cyc);
    end
    checks++;
    if (n4.o_result !== 32'h8000_0000) begin
      errors++; $display("FAIL lsb_result got %h want 80000000", n4.o_result);
    end
    checks++;
    if (n4.o_amount !== 6'd31) begin
      errors++; $display("FAIL lsb_amount got %0d want 31", n4.o_amount);
    end
    checks++;
    if (n4.o_zero !== 1'b0) begin
      errors++; $display("FAIL lsb_zero got %b want 0", n4.o_zero);
    end
    @(negedge clk);
    do_req(32'h8000_0000, cyc);
    checks++;
    if (cyc != 1) begin
      errors++; $display("FAIL msb_latency got %0d want 1", cyc);
    end
    checks++;
    if (n4.o_result !== 32'h8000_0000 || n4.o_amount !== 6'd0) begin
      errors++; $display("FAIL msb_out got %h/%0d want 80000000/0", n4.o_result, n4.o_amount);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_range();
    int cyc;
    do_req(32'h0001_2345, cyc);
    checks++;
    if (cyc != 4) begin
      errors++; $display("FAIL mid_latency got %0d want 4", cyc);
    end
    checks++;
    if (n4.o_result !== 32'h91A2_8000) begin
      errors++; $display("FAIL mid_result got %h want 91a28000", n4.o_result);
    end
    checks++;
    if (n4.o_amount !== 6'd15) begin
      errors++; $display("FAIL mid_amount got %0d want 15", n4.o_amount);
    end
    @(negedge clk);
  endtask

  task automatic test_zero();
    int cyc;
    do_req(32'h0, cyc);
    checks++;
    if (cyc != 0) begin
      errors++; $display("FAIL zero_latency got %0d want 0", cyc);
    end
    checks++;
    if (n4.o_result !== 32'h0 || n4.o_amount !== 6'd32 || n4.o_zero !== 1'b1) begin
      errors++; $display("FAIL zero_out got %h/%0d/%b want 0/32/1",
                         n4.o_result, n4.o_amount, n4.o_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int cyc;
    n4.i_ready = 1'b0;
    do_req(32'h00F0_0000, cyc);
    checks++;
    if (cyc != 3) begin
      errors++; $display("FAIL bp_latency got %0d want 3", cyc);
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (n4.o_valid !== 1'b1 || n4.o_result !== 32'hF000_0000) begin
        errors++; $display("FAIL bp_hold_result cycle %0d got v=%b %h want v=1 f0000000",
                           c, n4.o_valid, n4.o_result);
      end
      checks++;
      if (n4.o_amount !== 6'd8 || n4.o_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold_amount cycle %0d got %0d rdy=%b want 8 rdy=0",
                           c, n4.o_amount, n4.o_ready);
      end
      @(negedge clk);
    end
    n4.i_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (n4.o_ready !== 1'b1 || n4.o_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got rdy=%b v=%b want rdy=1 v=0",
                         n4.o_ready, n4.o_valid);
    end
  endtask

  task automatic test_flush();
    logic seen;
    @(negedge clk);
    n4.i_valid  = 1'b1;
    n4.i_source = 32'h0000_0001;
    @(negedge clk);
    n4.i_valid  = 1'b0;
    repeat (2) @(negedge clk);
    n4.i_flush = 1'b1;
    @(negedge clk);
    n4.i_flush = 1'b0;
    checks++;
    if (n4.o_ready !== 1'b1 || n4.o_valid !== 1'b0) begin
      errors++; $display("FAIL flush_busy got rdy=%b v=%b want rdy=1 v=0",
                         n4.o_ready, n4.o_valid);
    end
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (n4.o_valid) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL flush_no_valid got %b want 0", seen);
    end
    // Flush beside a request in IDLE drops it (zero operand would show at once).
    n4.i_valid  = 1'b1;
    n4.i_source = 32'h0;
    n4.i_flush  = 1'b1;
    @(negedge clk);
    n4.i_valid = 1'b0;
    n4.i_flush = 1'b0;
    checks++;
    if (n4.o_valid !== 1'b0 || n4.o_ready !== 1'b1) begin
      errors++; $display("FAIL flush_idle_drop got v=%b rdy=%b want v=0 rdy=1",
                         n4.o_valid, n4.o_ready);
    end
    @(negedge clk);
    checks++;
    if (n4.o_valid !== 1'b0) begin
      errors++; $display("FAIL flush_idle_later got v=%b want 0", n4.o_valid);
    end
  endtask

  task automatic test_reset_mid_busy();
    int cyc;
    @(negedge clk);
    n4.i_valid  = 1'b1;
    n4.i_source = 32'h0000_0001;
    @(negedge clk);
    n4.i_valid  = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (n4.o_ready !== 1'b1 || n4.o_valid !== 1'b0) begin
      errors++; $display("FAIL arst_handshake got rdy=%b v=%b want rdy=1 v=0",
                         n4.o_ready, n4.o_valid);
    end
    checks++;
    if (n4.o_result !== 32'h0 || n4.o_amount !== 6'd0 || n4.o_zero !== 1'b0) begin
      errors++; $display("FAIL arst_outputs got %h/%0d/%b want 0/0/0",
                         n4.o_result, n4.o_amount, n4.o_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_req(32'h4000_0000, cyc);
    checks++;
    if (cyc != 1 || n4.o_amount !== 6'd1 || n4.o_result !== 32'h8000_0000) begin
      errors++; $display("FAIL arst_next got lat=%0d amt=%0d res=%h want 1/1/80000000",
                         cyc, n4.o_amount, n4.o_result);
    end
    @(negedge clk);
  endtask

  // Same operand into STEP=1/4/32 instances; compare against a reference CLZ.
  task automatic run_sweep(input logic [31:0] src);
    int          exp_clz;
    logic [31:0] exp_res;
    int          steps [3];
    int          lat   [3];
    logic        seen  [3];
    logic [5:0]  amt   [3];
    logic [31:0] res   [3];
    steps[0] = 1; steps[1] = 4; steps[2] = 32;
    for (int d = 0; d < 3; d++) begin
      lat[d] = 100; seen[d] = 1'b0; amt[d] = '0; res[d] = '0;
    end
    exp_clz = ref_clz(src);
    exp_res = src << exp_clz;
    @(negedge clk);
    n1.i_valid = 1'b1;  n1.i_source = src;
    n4.i_valid = 1'b1;  n4.i_source = src;
    n32.i_valid = 1'b1; n32.i_source = src;
    @(negedge clk);
    n1.i_valid = 1'b0; n4.i_valid = 1'b0; n32.i_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!seen[0] && n1.o_valid) begin
        seen[0] = 1'b1; lat[0] = c; amt[0] = n1.o_amount; res[0] = n1.o_result;
      end
      if (!seen[1] && n4.o_valid) begin
        seen[1] = 1'b1; lat[1] = c; amt[1] = n4.o_amount; res[1] = n4.o_result;
      end
      if (!seen[2] && n32.o_valid) begin
        seen[2] = 1'b1; lat[2] = c; amt[2] = n32.o_amount; res[2] = n32.o_result;
      end
      @(negedge clk);
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (amt[d] !== 6'(exp_clz)) begin
        errors++; $display("FAIL sweep_amount step %0d src %h got %0d want %0d",
                           steps[d], src, amt[d], exp_clz);
      end
      checks++;
      if (res[d] !== exp_res) begin
        errors++; $display("FAIL sweep_result step %0d src %h got %h want %h",
                           steps[d], src, res[d], exp_res);
      end
      checks++;
      if (lat[d] != exp_clz / steps[d] + 1) begin
        errors++; $display("FAIL sweep_latency step %0d src %h got %0d want %0d",
                           steps[d], src, lat[d], exp_clz / steps[d] + 1);
      end
    end
  endtask

  task automatic test_sweep();
    logic [31:0] v;
    for (int b = 0; b < 32; b += 5) begin
      v = 32'h1 << b;
      run_sweep(v);
    end
    run_sweep(32'h8000_0000);
    for (int r = 0; r < 8; r++) begin
      v = $urandom >> $urandom_range(0, 31);
      if (v == 32'h0) v = 32'h0000_0003;
      run_sweep(v);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    n1.i_flush = 1'b0;  n1.i_valid = 1'b0;  n1.i_source = '0;  n1.i_ready = 1'b1;
    n4.i_flush = 1'b0;  n4.i_valid = 1'b0;  n4.i_source = '0;  n4.i_ready = 1'b1;
    n32.i_flush = 1'b0; n32.i_valid = 1'b0; n32.i_source = '0; n32.i_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_bit();
    test_mid_range();
    test_zero();
    test_backpressure();
    test_flush();
    test_reset_mid_busy();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zap_normalizer.md
Name: zap_normalizer

Overview:
- Iterative normalizer that runs in the opposite direction to the barrel shifter.
- Given a 32-bit operand, it finds the left-shift amount that brings the leading 1 to bit 31.
- It returns the normalized value, the shift amount and a zero flag.
- It sits beside the shifter in the execute stage and serves CLZ-style and normalization operations through a valid/ready handshake.

Parameters:
- WIDTH, 32, operand width in bits; power of 2, at least 8.
- STEP, 4, maximum bits examined and shifted per busy cycle; power of 2, between 1 and WIDTH.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_reset_n  input  1  asynchronous active-low reset.
- i_flush  input  1  synchronous abort; returns the block to IDLE.
- i_valid  input  1  request valid.
- o_ready  output  1  block can accept a request; high only in IDLE.
- i_source  input  WIDTH  operand, sampled when i_valid && o_ready.
- o_valid  output  1  result valid; high only in DONE.
- i_ready  input  1  consumer accepts the result.
- o_result  output  WIDTH  normalized operand (i_source << o_amount).
- o_amount  output  $clog2(WIDTH)+1  leading-zero count, 0..WIDTH.
- o_zero  output  1  operand was zero.

Behaviour:
- Reset (async, i_reset_n low): state=IDLE, work reg=0, count=0.
  - Outputs: o_ready=1, o_valid=0, o_result=0, o_amount=0, o_zero=0.
  - Reset asserted mid-operation discards the operation; no result is produced.
- States are IDLE, BUSY and DONE. o_ready is 1 in IDLE only. o_valid is 1 in DONE only.
- IDLE, on i_valid && o_ready: capture i_source into work, clear count.
  - If i_source==0: go to DONE with result=0, amount=WIDTH, zero=1.
  - Otherwise go to BUSY with zero=0.
  - With no request, stay in IDLE.
- BUSY, each cycle:
  - If work[WIDTH-1 -: STEP] is all zero: work <<= STEP, count += STEP, stay in BUSY.
  - Otherwise: let z = leading zeros within the top STEP bits (0..STEP-1). Then work <<= z, count += z, go to DONE.
- Termination is guaranteed because the operand is nonzero. The count never exceeds WIDTH-1 in BUSY.
- Latency: the accept edge is k.
  - Nonzero operand: o_valid rises after edge k+floor(clz/STEP)+1.
  - Zero operand: o_valid rises after edge k.
- DONE:
  - o_result=work, o_amount=count; both stay stable while i_ready=0, for any length of backpressure.
  - When i_ready=1, go to IDLE on that edge.
  - A new request cannot be accepted in the same cycle (one-bubble throughput, by design).
- i_flush has priority over all transitions except reset.
  - In any state it forces IDLE on the next edge and clears o_valid.
  - Datapath registers may retain stale values; outputs are defined only while o_valid=1.
  - i_flush together with i_valid in IDLE: the request is dropped.
- Arithmetic:
  - count is $clog2(WIDTH)+1 bits wide, with no wrap.
  - Shifts are logical left with zero fill; no carry or saturation output.
- i_source is ignored outside the accept cycle.
- i_valid held high with no accept is legal; the request is taken once the block returns to IDLE.

Test Plan:
- Single-bit and MSB cases:
  - STEP=4, i_source=0x0000_0001 -> 8 BUSY cycles; o_result=0x8000_0000, o_amount=31, o_zero=0.
  - i_source=0x8000_0000 -> 1 BUSY cycle; o_result=0x8000_0000, o_amount=0.
- Mid-range operand: i_source=0x0001_2345 -> 4 BUSY cycles; o_result=0x91A2_8000, o_amount=15.
- Zero operand: i_source=0 -> o_valid one edge after accept; o_result=0, o_amount=32, o_zero=1; no BUSY state visited.
- Backpressure: i_ready held low 5 cycles after o_valid for 0x00F0_0000 -> o_result=0xF000_0000 and o_amount=8 stable throughout. o_ready rises one edge after i_ready=1.
- Abort cases:
  - i_flush during BUSY for 0x0000_0001 -> IDLE next edge; o_valid never rises.
  - Async i_reset_n low mid-BUSY -> o_ready=1, all outputs 0 immediately.
  - The next request 0x4000_0000 then yields o_amount=1.
- Sweep: STEP in {1,4,32} with random and one-hot operands -> o_amount matches a reference CLZ, o_result==i_source<<o_amount, and latency matches floor(clz/STEP)+1.
